// File: rtl/demux18_dispatch.sv
// demux18_dispatch: registered 1-to-8 demultiplexer for DW-bit words.
// A single valid/ready input stream is steered into one of eight lane holding
// registers (or all of them on broadcast). Each lane keeps its word until its
// consumer takes it, so a slow consumer backpressures the source. A lane that
// is popped on the same edge it is reloaded stays full with the new word.
module demux18_dispatch #(
   parameter int DW   = 14,
   parameter int NOUT = 8,
   parameter int CW   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DW-1:0]        in_data,
   input  logic [2:0]           in_sel,
   input  logic                 in_bcast,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [NOUT*DW-1:0]   out_data,
   output logic [NOUT-1:0]      out_valid,
   input  logic [NOUT-1:0]      out_ready,
   output logic [CW-1:0]        accept_cnt,
   output logic [CW-1:0]        stall_cnt
);

   // Per-lane occupancy state: a lane is either empty or holds one word.
   typedef enum logic {
      LANE_EMPTY = 1'b0,
      LANE_FULL  = 1'b1
   } lane_state_t;

   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   // True when the current transfer targets the given lane.
   function automatic logic lane_hit(input logic [2:0] sel,
                                     input logic       bcast,
                                     input logic [2:0] lane_idx);
      return bcast | (sel == lane_idx);
   endfunction

   // Saturating increment: sticks at all-ones instead of wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] value);
      logic [CW-1:0] result;
      if (value == CNT_MAX) begin
         result = value;
      end else begin
         result = value + CNT_ONE;
      end
      return result;
   endfunction

   lane_state_t         state_r     [NOUT];
   lane_state_t         state_nxt_s [NOUT];
   logic [DW-1:0]       data_r      [NOUT];
   logic [NOUT-1:0]     lane_free_s;
   logic [NOUT-1:0]     load_s;
   logic [NOUT-1:0]     pop_s;
   logic                accept_s;
   logic                stall_s;
   logic [CW-1:0]       accept_cnt_r;
   logic [CW-1:0]       stall_cnt_r;

   // A lane can take a word when it is empty or is being emptied this cycle.
   always_comb begin
      lane_free_s = {NOUT{1'b0}};
      for (int k = 0; k < NOUT; k++) begin
         lane_free_s[k] = (state_r[k] == LANE_EMPTY) | out_ready[k];
      end
   end

   // Input readiness depends only on the target lane(s), never on in_valid.
   always_comb begin
      in_ready = 1'b0;
      if (in_bcast) begin
         in_ready = &lane_free_s;
      end else begin
         in_ready = lane_free_s[in_sel];
      end
   end

   // Transfer qualifiers for this cycle.
   always_comb begin
      accept_s = 1'b0;
      stall_s  = 1'b0;
      if (in_valid) begin
         accept_s = in_ready;
         stall_s  = ~in_ready;
      end else begin
         accept_s = 1'b0;
         stall_s  = 1'b0;
      end
   end

   // Per-lane load and pop strobes.
   always_comb begin
      load_s = {NOUT{1'b0}};
      pop_s  = {NOUT{1'b0}};
      for (int k = 0; k < NOUT; k++) begin
         load_s[k] = accept_s & lane_hit(in_sel, in_bcast, 3'(k));
         pop_s[k]  = (state_r[k] == LANE_FULL) & out_ready[k];
      end
   end

   // Lane occupancy next state: load has priority over pop, so pop+load stays full.
   always_comb begin
      for (int k = 0; k < NOUT; k++) begin
         state_nxt_s[k] = state_r[k];
         case (state_r[k])
            LANE_EMPTY: begin
               if (load_s[k]) begin
                  state_nxt_s[k] = LANE_FULL;
               end else begin
                  state_nxt_s[k] = LANE_EMPTY;
               end
            end
            LANE_FULL: begin
               if (load_s[k]) begin
                  state_nxt_s[k] = LANE_FULL;
               end else if (pop_s[k]) begin
                  state_nxt_s[k] = LANE_EMPTY;
               end else begin
                  state_nxt_s[k] = LANE_FULL;
               end
            end
            default: begin
               state_nxt_s[k] = LANE_EMPTY;
            end
         endcase
      end
   end

   // Lane occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NOUT; k++) begin
            state_r[k] <= LANE_EMPTY;
         end
      end else begin
         for (int k = 0; k < NOUT; k++) begin
            state_r[k] <= state_nxt_s[k];
         end
      end
   end

   // Lane data registers: capture on load, otherwise hold (a pop keeps the old word).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NOUT; k++) begin
            data_r[k] <= {DW{1'b0}};
         end
      end else begin
         for (int k = 0; k < NOUT; k++) begin
            if (load_s[k]) begin
               data_r[k] <= in_data;
            end else begin
               data_r[k] <= data_r[k];
            end
         end
      end
   end

   // Accept counter wraps; stall counter saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         accept_cnt_r <= CNT_ZERO;
         stall_cnt_r  <= CNT_ZERO;
      end else begin
         if (accept_s) begin
            accept_cnt_r <= accept_cnt_r + CNT_ONE;
         end else begin
            accept_cnt_r <= accept_cnt_r;
         end
         if (stall_s) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end

   // Flatten lane registers onto the output bus; valid mirrors lane occupancy.
   always_comb begin
      out_data  = {(NOUT*DW){1'b0}};
      out_valid = {NOUT{1'b0}};
      for (int k = 0; k < NOUT; k++) begin
         out_data[k*DW +: DW] = data_r[k];
         out_valid[k]         = (state_r[k] == LANE_FULL);
      end
   end

   // Counter outputs come straight from their registers.
   always_comb begin
      accept_cnt = accept_cnt_r;
      stall_cnt  = stall_cnt_r;
   end

endmodule

// File: tb/tb_demux18_dispatch.sv
// Directed self-checking bench for demux18_dispatch. A second instance with
// 8-bit counters exercises counter saturation within a short run.
module tb_demux18_dispatch;

   logic          clk;
   logic          rst;
   logic [13:0]   in_data;
   logic [2:0]    in_sel;
   logic          in_bcast;
   logic          in_valid;
   logic          in_ready;
   logic [111:0]  out_data;
   logic [7:0]    out_valid;
   logic [7:0]    out_ready;
   logic [15:0]   accept_cnt;
   logic [15:0]   stall_cnt;

   logic [13:0]   s_in_data;
   logic [2:0]    s_in_sel;
   logic          s_in_bcast;
   logic          s_in_valid;
   logic          s_in_ready;
   logic [111:0]  s_out_data;
   logic [7:0]    s_out_valid;
   logic [7:0]    s_out_ready;
   logic [7:0]    s_accept_cnt;
   logic [7:0]    s_stall_cnt;

   int n_cmp;
   int n_mis;
   int pop6_cnt;
   int pop6_base;

   demux18_dispatch dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
      .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .accept_cnt(accept_cnt), .stall_cnt(stall_cnt)
   );

   demux18_dispatch #(.DW(14), .NOUT(8), .CW(8)) dut_small (
      .clk(clk), .rst(rst), .in_data(s_in_data), .in_sel(s_in_sel),
      .in_bcast(s_in_bcast), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .accept_cnt(s_accept_cnt), .stall_cnt(s_stall_cnt)
   );

   // Free-running clock, rising edge active.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count lane-6 pops as seen by the DUT at each active edge.
   initial pop6_cnt = 0;
   always @(posedge clk) begin
      if (out_valid[6] & out_ready[6]) pop6_cnt = pop6_cnt + 1;
   end

   function automatic logic [13:0] lane_of(input logic [111:0] bus, input int k);
      return bus[k*14 +: 14];
   endfunction

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp = n_cmp + 1;
      if (got !== exp) begin
         n_mis = n_mis + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_mis = 0;
      rst = 1'b1;
      in_data = 14'h0000; in_sel = 3'd0; in_bcast = 1'b0; in_valid = 1'b0; out_ready = 8'h00;
      s_in_data = 14'h0000; s_in_sel = 3'd0; s_in_bcast = 1'b0; s_in_valid = 1'b0; s_out_ready = 8'h00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check_val("rst_valid", 128'(out_valid), 128'h0);
      check_val("rst_data", 128'(out_data), 128'h0);
      check_val("rst_acc", 128'(accept_cnt), 128'h0);
      check_val("rst_stall", 128'(stall_cnt), 128'h0);
      check_val("rst_ready", 128'(in_ready), 128'h1);

      // Reset mid-operation: fill lanes 2 and 5, then pulse rst between edges.
      in_valid = 1'b1; in_sel = 3'd2; in_data = 14'h0222;
      tick();
      in_sel = 3'd5; in_data = 14'h0555;
      tick();
      in_valid = 1'b0;
      check_val("mid_valid_pre", 128'(out_valid), 128'h24);
      check_val("mid_acc_pre", 128'(accept_cnt), 128'h2);
      rst = 1'b1;
      #1;
      check_val("mid_valid", 128'(out_valid), 128'h0);
      check_val("mid_data", 128'(out_data), 128'h0);
      check_val("mid_acc", 128'(accept_cnt), 128'h0);
      check_val("mid_stall", 128'(stall_cnt), 128'h0);
      #1 rst = 1'b0;
      tick();

      // Unicast sweep over all lanes with consumers stalled.
      out_ready = 8'h00;
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1; in_sel = 3'(k); in_data = 14'h1000 + 14'(k);
         #1;
         check_val("sweep_ready", 128'(in_ready), 128'h1);
         tick();
      end
      in_valid = 1'b0;
      check_val("sweep_valid", 128'(out_valid), 128'hFF);
      for (int k = 0; k < 8; k++) begin
         check_val("sweep_lane", 128'(lane_of(out_data, k)), 128'h1000 + 128'(k));
      end
      check_val("sweep_acc", 128'(accept_cnt), 128'h8);
      check_val("sweep_stall", 128'(stall_cnt), 128'h0);

      // Backpressure on lane 3, then release the consumer.
      in_valid = 1'b1; in_sel = 3'd3; in_data = 14'h0333;
      #1;
      check_val("bp_ready", 128'(in_ready), 128'h0);
      for (int i = 0; i < 4; i++) tick();
      check_val("bp_lane3_hold", 128'(lane_of(out_data, 3)), 128'h1003);
      check_val("bp_stall", 128'(stall_cnt), 128'h4);
      check_val("bp_acc_hold", 128'(accept_cnt), 128'h8);
      out_ready = 8'h08;
      #1;
      check_val("bp_ready_rel", 128'(in_ready), 128'h1);
      tick();
      in_valid = 1'b0; out_ready = 8'h00;
      check_val("bp_lane3_new", 128'(lane_of(out_data, 3)), 128'h0333);
      check_val("bp_valid", 128'(out_valid), 128'hFF);
      check_val("bp_acc", 128'(accept_cnt), 128'h9);
      check_val("bp_stall_fin", 128'(stall_cnt), 128'h4);

      // Pop+load on lane 6: empty it, load 0x0ABC, then pop and load 0x3FFF together.
      out_ready = 8'h40;
      tick();
      out_ready = 8'h00;
      check_val("pl_empty", 128'(out_valid), 128'hBF);
      check_val("pl_hold_data", 128'(lane_of(out_data, 6)), 128'h1006);
      in_valid = 1'b1; in_sel = 3'd6; in_data = 14'h0ABC;
      tick();
      check_val("pl_lane6_abc", 128'(lane_of(out_data, 6)), 128'h0ABC);
      pop6_base = pop6_cnt;
      out_ready = 8'h40; in_data = 14'h3FFF;
      #1;
      check_val("pl_ready", 128'(in_ready), 128'h1);
      tick();
      in_valid = 1'b0; out_ready = 8'h00;
      tick();
      check_val("pl_lane6", 128'(lane_of(out_data, 6)), 128'h3FFF);
      check_val("pl_valid6", 128'(out_valid[6]), 128'h1);
      check_val("pl_pops", 128'(pop6_cnt - pop6_base), 128'h1);
      check_val("pl_acc", 128'(accept_cnt), 128'd11);

      // Broadcast into all-empty lanes.
      out_ready = 8'hFF;
      tick();
      out_ready = 8'h00;
      check_val("bc_empty", 128'(out_valid), 128'h00);
      in_valid = 1'b1; in_bcast = 1'b1; in_data = 14'h2A5A; in_sel = 3'd4;
      #1;
      check_val("bc_ready", 128'(in_ready), 128'h1);
      tick();
      in_valid = 1'b0;
      check_val("bc_valid", 128'(out_valid), 128'hFF);
      for (int k = 0; k < 8; k++) begin
         check_val("bc_lane", 128'(lane_of(out_data, k)), 128'h2A5A);
      end
      check_val("bc_acc", 128'(accept_cnt), 128'd12);

      // Broadcast blocked by lane 0 full and not ready.
      out_ready = 8'hFE; in_valid = 1'b1; in_bcast = 1'b1; in_data = 14'h1555;
      #1;
      check_val("bc_blk_ready", 128'(in_ready), 128'h0);
      tick();
      in_valid = 1'b0; in_bcast = 1'b0; out_ready = 8'h00;
      check_val("bc_blk_valid", 128'(out_valid), 128'h01);
      for (int k = 0; k < 8; k++) begin
         check_val("bc_blk_lane", 128'(lane_of(out_data, k)), 128'h2A5A);
      end
      check_val("bc_blk_acc", 128'(accept_cnt), 128'd12);
      check_val("bc_blk_stall", 128'(stall_cnt), 128'd5);
      in_sel = 3'd1;
      #1;
      check_val("uc_free_ready", 128'(in_ready), 128'h1);
      in_sel = 3'd0;
      #1;
      check_val("uc_full_ready", 128'(in_ready), 128'h0);

      // Accept counter wrap: stream into lane 7 with its consumer always ready.
      in_valid = 1'b1; in_sel = 3'd7; out_ready = 8'h80;
      for (int i = 0; i < 65523; i++) begin
         in_data = 14'(i);
         tick();
      end
      check_val("wrap_acc_max", 128'(accept_cnt), 128'hFFFF);
      in_data = 14'h1234;
      tick();
      in_valid = 1'b0; out_ready = 8'h00;
      check_val("wrap_acc_zero", 128'(accept_cnt), 128'h0);
      check_val("wrap_lane7", 128'(lane_of(out_data, 7)), 128'h1234);
      check_val("wrap_stall", 128'(stall_cnt), 128'd5);

      // Narrow-counter instance: stall saturation and accept wrap.
      s_in_valid = 1'b1; s_in_sel = 3'd0; s_in_data = 14'h0011; s_out_ready = 8'h00;
      tick();
      check_val("s_acc1", 128'(s_accept_cnt), 128'h1);
      for (int i = 0; i < 254; i++) tick();
      check_val("s_stall_fe", 128'(s_stall_cnt), 128'hFE);
      tick();
      check_val("s_stall_ff", 128'(s_stall_cnt), 128'hFF);
      for (int i = 0; i < 45; i++) tick();
      check_val("s_stall_sat", 128'(s_stall_cnt), 128'hFF);
      check_val("s_lane0_hold", 128'(lane_of(s_out_data, 0)), 128'h0011);
      s_out_ready = 8'h01;
      for (int i = 0; i < 255; i++) tick();
      check_val("s_acc_wrap", 128'(s_accept_cnt), 128'h0);
      check_val("s_stall_keep", 128'(s_stall_cnt), 128'hFF);
      s_in_valid = 1'b0; s_out_ready = 8'h00;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
